mem_access: RTL

Memory-access stage of the 64-bit RV64 pipeline. It sits between execute and writeback, and performs loads and stores over the data bus with a valid/ok handshake. It aligns store data and builds byte strobes, and sign- or zero-extends load data. It holds one instruction at a time. Its output bundle drives the register-file write port: write enable is `out_valid & out_wen`, with `out_rd` and `out_data`.

---
 rtl/common_pkg.sv | 68 ++++++
 rtl/mem_access_align.sv | 69 ++++++
 rtl/mem_access.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// ============================================================================
// Module   : common (package)
// Brief    : Shared RV64 pipeline types for the memory-access stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;

    typedef logic [63:0] data_data_t;
    typedef logic [4:0]  creg_addr_t;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LD   = 4'd4,
        LBU  = 4'd5,
        LHU  = 4'd6,
        LWU  = 4'd7,
        SB   = 4'd8,
        SH   = 4'd9,
        SW   = 4'd10,
        SD   = 4'd11
    } mem_op_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic       valid;
        data_data_t addr;
        msize_t     size;
        logic [7:0] strobe;
        data_data_t data;
    } dbus_req_t;

    typedef struct packed {
        logic       addr_ok;
        logic       data_ok;
        data_data_t data;
    } dbus_resp_t;

    typedef struct packed {
        data_data_t pc;
        creg_addr_t rd;
        logic       wen;
        data_data_t data;
        logic       exc;
    } mem_stage_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LD) ||
               (op == LBU) || (op == LHU) || (op == LWU);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW) || (op == SD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_align.sv
// ============================================================================
// Module   : mem_align
// Brief    : Combinational size/strobe/alignment and load-extension helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
    import common::*;
(
    input  mem_op_t    op,
    input  logic [2:0] off,
    input  data_data_t wdata,
    input  data_data_t rdata,
    output logic [7:0] strobe,
    output msize_t     size,
    output data_data_t sdata,
    output data_data_t ldata,
    output logic       misalign
);

    data_data_t w_rshift;
    logic [7:0] w_base;

    always_comb begin
        w_rshift = rdata >> {off, 3'b000};
        sdata    = wdata << {off, 3'b000};

        case (op)
            LB, LBU, SB: size = MSIZE1;
            LH, LHU, SH: size = MSIZE2;
            LW, LWU, SW: size = MSIZE4;
            default:     size = MSIZE8;
        endcase

        case (op)
            SB:      w_base = 8'h01;
            SH:      w_base = 8'h03;
            SW:      w_base = 8'h0f;
            SD:      w_base = 8'hff;
            default: w_base = 8'h00;
        endcase
        strobe = w_base << off;

        // NONE carries no memory access, so it can never be misaligned
        case (size)
            MSIZE2:  misalign = off[0];
            MSIZE4:  misalign = |off[1:0];
            MSIZE8:  misalign = |off;
            default: misalign = 1'b0;
        endcase
        if (op == NONE) begin
            misalign = 1'b0;
        end

        case (op)
            LB:      ldata = {{56{w_rshift[7]}},  w_rshift[7:0]};
            LH:      ldata = {{48{w_rshift[15]}}, w_rshift[15:0]};
            LW:      ldata = {{32{w_rshift[31]}}, w_rshift[31:0]};
            LBU:     ldata = {56'd0, w_rshift[7:0]};
            LHU:     ldata = {48'd0, w_rshift[15:0]};
            LWU:     ldata = {32'd0, w_rshift[31:0]};
            default: ldata = w_rshift;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module   : mem_access
// Brief    : RV64 memory-access stage; one instruction in flight on a valid/ok bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
    import common::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  data_data_t in_pc,
    input  data_data_t in_alu,
    input  data_data_t in_wdata,
    input  creg_addr_t in_rd,
    input  logic       in_wen,
    input  mem_op_t    in_memop,
    output logic       dreq_valid,
    output data_data_t dreq_addr,
    output msize_t     dreq_size,
    output logic [7:0] dreq_strobe,
    output data_data_t dreq_data,
    input  logic       dresp_addr_ok,
    input  logic       dresp_data_ok,
    input  data_data_t dresp_data,
    output logic       out_valid,
    input  logic       out_ready,
    output data_data_t out_pc,
    output creg_addr_t out_rd,
    output logic       out_wen,
    output data_data_t out_data,
    output logic       out_exc
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0] r_state;
    mem_stage_t r_entry;
    mem_op_t    r_op;
    data_data_t r_addr;
    data_data_t r_wdata;

    mem_op_t    w_op;
    logic [2:0] w_off;
    logic [7:0] w_strobe;
    msize_t     w_size;
    data_data_t w_sdata;
    data_data_t w_ldata;
    logic       w_misalign;
    logic       w_accept;
    dbus_req_t  w_req;
    dbus_resp_t w_resp;

    // The aligner sees the incoming op while idle (misalign decision) and the latched op afterwards
    assign w_op     = (r_state == c_IDLE) ? in_memop     : r_op;
    assign w_off    = (r_state == c_IDLE) ? in_alu[2:0]  : r_addr[2:0];
    assign w_accept = in_valid & in_ready;
    assign w_resp   = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};

    mem_align u_align (
        .op       (w_op),
        .off      (w_off),
        .wdata    (r_wdata),
        .rdata    (w_resp.data),
        .strobe   (w_strobe),
        .size     (w_size),
        .sdata    (w_sdata),
        .ldata    (w_ldata),
        .misalign (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_entry <= '0;
            r_op    <= NONE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_entry.pc <= in_pc;
                        r_entry.rd <= in_rd;
                        r_op       <= in_memop;
                        r_addr     <= in_alu;
                        r_wdata    <= in_wdata;
                        if (in_memop == NONE) begin
                            r_entry.wen  <= in_wen;
                            r_entry.data <= in_alu;
                            r_entry.exc  <= 1'b0;
                            r_state      <= c_DONE;
                        end else if (w_misalign) begin
                            r_entry.wen  <= 1'b0;
                            r_entry.data <= '0;
                            r_entry.exc  <= 1'b1;
                            r_state      <= c_DONE;
                        end else begin
                            r_entry.wen  <= is_load(in_memop) & in_wen;
                            r_entry.data <= '0;
                            r_entry.exc  <= 1'b0;
                            r_state      <= c_REQ;
                        end
                    end
                end
                c_REQ: begin
                    if (w_resp.addr_ok) begin
                        if (w_resp.data_ok) begin
                            if (is_load(r_op)) begin
                                r_entry.data <= w_ldata;
                            end
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (w_resp.data_ok) begin
                        if (is_load(r_op)) begin
                            r_entry.data <= w_ldata;
                        end
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_req.valid  = (r_state == c_REQ);
        w_req.addr   = r_addr;
        w_req.size   = w_size;
        w_req.strobe = w_req.valid ? w_strobe : 8'h00;
        w_req.data   = w_sdata;
    end

    assign in_ready    = (r_state == c_IDLE);
    assign dreq_valid  = w_req.valid;
    assign dreq_addr   = w_req.addr;
    assign dreq_size   = w_req.size;
    assign dreq_strobe = w_req.strobe;
    assign dreq_data   = w_req.data;

    assign out_valid = (r_state == c_DONE);
    assign out_pc    = r_entry.pc;
    assign out_rd    = r_entry.rd;
    assign out_wen   = r_entry.wen;
    assign out_data  = r_entry.data;
    assign out_exc   = r_entry.exc;

endmodule

`default_nettype wire
